load_store_unit: RTL

- Executes the memory access requested by the decoder's memWrite/DQM/load controls.
- Drives a single-outstanding req/ack data bus and stalls the pipeline until the access completes.
- Performs byte-lane steering and write-data replication for stores.
- Performs lane extraction and sign/zero extension for loads.
- Sits between the execute stage and the data memory / SDRAM bus bridge.

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and the memory bridge.
// master drives busReq/busWe/busAddr/busByteEn/busWData; slave returns busRData/busAck.
interface load_store_unit_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busByteEn;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        busAck;

    modport master (
        output busReq, busWe, busAddr, busByteEn, busWData,
        input  busRData, busAck
    );

    modport slave (
        input  busReq, busWe, busAddr, busByteEn, busWData,
        output busRData, busAck
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/ack data access with lane steering.
// Ports: clk, rst_n, memRead/memWrite/DQM/loadUnsigned/addr/writeData in, readData/stall/misaligned/busError out, bus (master).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic [1:0]               DQM,
    input  logic                     loadUnsigned,
    input  logic [31:0]              addr,
    input  logic [31:0]              writeData,
    output logic [31:0]              readData,
    output logic                     stall,
    output logic                     misaligned,
    output logic                     busError,
    load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;

    logic        req;
    logic        is_byte;
    logic        is_half;
    logic        aligned;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_n;

    assign req     = memRead | memWrite;
    assign is_byte = (DQM == 2'b00);
    assign is_half = (DQM == 2'b01);
    assign aligned = is_byte
                   | (is_half & ~addr[0])
                   | (~is_byte & ~is_half & (addr[1:0] == 2'b00));

    always_comb begin
        be_n = 4'b1111;
        wd_n = writeData;
        unique case (1'b1)
            is_byte: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{writeData[7:0]}};
            end
            is_half: begin
                be_n = 4'b0011 << {addr[1], 1'b0};
                wd_n = {2{writeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the offset/size latched at request time.
    always_comb begin
        sh     = bus.busRData >> {off_q, 3'b000};
        lane_b = sh[7:0];
        lane_h = off_q[1] ? bus.busRData[31:16] : bus.busRData[15:0];
        load_n = bus.busRData;
        unique case (size_q)
            2'b00:   load_n = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_n = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_n = bus.busRData;
        endcase
    end

    // Gated by rst_n so stall reads 0 while reset is held.
    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    stall      = req & aligned;
                    misaligned = req & ~aligned;
                end
                BUSY:    stall = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            size_q        <= '0;
            off_q         <= '0;
            uns_q         <= 1'b0;
            readData      <= '0;
            busError      <= 1'b0;
            bus.busReq    <= 1'b0;
            bus.busWe     <= 1'b0;
            bus.busAddr   <= '0;
            bus.busByteEn <= '0;
            bus.busWData  <= '0;
        end else begin
            busError <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && aligned) begin
                        bus.busReq    <= 1'b1;
                        bus.busWe     <= memWrite;
                        bus.busAddr   <= {addr[31:2], 2'b00};
                        bus.busByteEn <= be_n;
                        bus.busWData  <= wd_n;
                        size_q        <= DQM;
                        off_q         <= addr[1:0];
                        uns_q         <= loadUnsigned;
                        cnt           <= '0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack has priority over an expiring timeout.
                    if (bus.busAck) begin
                        if (!bus.busWe) readData <= load_n;
                        bus.busReq <= 1'b0;
                        cnt        <= '0;
                        state      <= DONE;
                    end else if (cnt == LIMIT) begin
                        if (!bus.busWe) readData <= '0;
                        bus.busReq <= 1'b0;
                        busError   <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
